instr_fetch_unit: RTL and testbench

- Fetch stage that sits directly upstream of the control unit.
- Owns the program counter and runs a request/acknowledge handshake with instruction memory.
- Holds the fetched instruction stable in a register and presents decoded fields (op, funct3, funct7b5) to the control unit.
- Consumes the control unit's PCSrc and the datapath's branch/jump target to select the next PC when an instruction retires.

---
 rtl/instr_fetch_unit.sv | 135 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, runs the IMem req/ack handshake, and holds the
// instruction for the control unit. Optional target alignment check: MISALIGN_CHECK_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemRData,
  input  logic        Stall,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7b5,
  output logic        FetchFault
`ifdef MISALIGN_CHECK_EN
  ,
  output logic        FaultCause
`endif
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_FAULT} state_t;

  localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

  state_t      state, state_nxt;
  logic        req_en;
  logic [31:0] wdog_cnt, wdog_nxt, wdog_inc;
  logic [31:0] pc_nxt, instr_nxt, tgt_aligned;
  logic        fetch_live, ack_live, timeout;

`ifdef MISALIGN_CHECK_EN
  logic        cause_nxt;
  logic        misalign;
  assign misalign = PCSrc && (PCTarget[1:0] != 2'b00);
`else
  logic        unused_tgt_lsb;
  assign unused_tgt_lsb = ^PCTarget[1:0];
`endif

  // req_en keeps IMemReq low until the first clock edge after reset release
  assign fetch_live  = (state == S_FETCH) && req_en;
  assign ack_live    = fetch_live && IMemAck;
  assign wdog_inc    = wdog_cnt + 32'd1;
  assign timeout     = (TIMEOUT_LIM != 32'd0) && fetch_live && !IMemAck &&
                       (wdog_inc == TIMEOUT_LIM);
  assign tgt_aligned = {PCTarget[31:2], 2'b00};

  always_comb begin
    state_nxt = state;
    pc_nxt    = PC;
    instr_nxt = Instr;
    wdog_nxt  = wdog_cnt;
`ifdef MISALIGN_CHECK_EN
    cause_nxt = FaultCause;
`endif
    case (state)
      S_FETCH: begin
        if (ack_live) begin
          instr_nxt = IMemRData;
          wdog_nxt  = 32'd0;
          state_nxt = S_EXEC;
        end else if (timeout) begin
          wdog_nxt  = wdog_inc;
          state_nxt = S_FAULT;
`ifdef MISALIGN_CHECK_EN
          cause_nxt = 1'b0;
`endif
        end else if (fetch_live && (TIMEOUT_LIM != 32'd0)) begin
          wdog_nxt = wdog_inc;
        end
      end
      S_EXEC: begin
        if (!Stall) begin
`ifdef MISALIGN_CHECK_EN
          if (misalign) begin
            state_nxt = S_FAULT;
            cause_nxt = 1'b1;
          end else begin
            pc_nxt    = PCSrc ? tgt_aligned : PCPlus4;
            state_nxt = S_FETCH;
          end
`else
          pc_nxt    = PCSrc ? tgt_aligned : PCPlus4;
          state_nxt = S_FETCH;
`endif
        end
      end
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_FETCH;
      req_en   <= 1'b0;
      wdog_cnt <= 32'd0;
      PC       <= RESET_PC;
      Instr    <= 32'd0;
`ifdef MISALIGN_CHECK_EN
      FaultCause <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      req_en   <= 1'b1;
      wdog_cnt <= wdog_nxt;
      PC       <= pc_nxt;
      Instr    <= instr_nxt;
`ifdef MISALIGN_CHECK_EN
      FaultCause <= cause_nxt;
`endif
    end
  end

  assign IMemReq    = fetch_live;
  assign IMemAddr   = PC;
  assign PCPlus4    = PC + 32'd4;
  assign InstrValid = (state == S_EXEC);
  assign FetchFault = (state == S_FAULT);

  // Decode only from the held register so fields stay stable through stalls
  assign op       = Instr[6:0];
  assign funct3   = Instr[14:12];
  assign funct7b5 = Instr[30];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a main instance (RESET_PC=0, TIMEOUT=4)
// and a wrap instance (RESET_PC=FFFF_FFFC, watchdog disabled).
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset_n;

  logic        ack, stall, pcsrc;
  logic [31:0] rdata, tgt;
  logic        req, ivalid, ffault, f7b5;
  logic [31:0] addr, instr, pc, pcp4;
  logic [6:0]  opc;
  logic [2:0]  f3;

  logic        w_ack, w_stall, w_pcsrc;
  logic [31:0] w_rdata, w_tgt;
  logic        w_req, w_ivalid, w_ffault, w_f7b5;
  logic [31:0] w_addr, w_instr, w_pc, w_pcp4;
  logic [6:0]  w_opc;
  logic [2:0]  w_f3;

`ifdef MISALIGN_CHECK_EN
  logic        fcause, w_fcause;
`endif

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(4)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .IMemReq(req), .IMemAddr(addr), .IMemAck(ack), .IMemRData(rdata),
    .Stall(stall), .PCSrc(pcsrc), .PCTarget(tgt),
    .InstrValid(ivalid), .Instr(instr), .PC(pc), .PCPlus4(pcp4),
    .op(opc), .funct3(f3), .funct7b5(f7b5), .FetchFault(ffault)
`ifdef MISALIGN_CHECK_EN
    , .FaultCause(fcause)
`endif
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT_CYCLES(0)) u_wrap (
    .clk(clk), .reset_n(reset_n),
    .IMemReq(w_req), .IMemAddr(w_addr), .IMemAck(w_ack), .IMemRData(w_rdata),
    .Stall(w_stall), .PCSrc(w_pcsrc), .PCTarget(w_tgt),
    .InstrValid(w_ivalid), .Instr(w_instr), .PC(w_pc), .PCPlus4(w_pcp4),
    .op(w_opc), .funct3(w_f3), .funct7b5(w_f7b5), .FetchFault(w_ffault)
`ifdef MISALIGN_CHECK_EN
    , .FaultCause(w_fcause)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    ack = 1'b0; rdata = '0; stall = 1'b0; pcsrc = 1'b0; tgt = '0;
    w_ack = 1'b0; w_rdata = '0; w_stall = 1'b0; w_pcsrc = 1'b0; w_tgt = '0;
    repeat (2) step();

    chk("rst_req",    32'(req),    32'd0);
    chk("rst_valid",  32'(ivalid), 32'd0);
    chk("rst_pc",     pc,          32'h0000_0000);
    chk("rst_instr",  instr,       32'd0);
    chk("rst_op",     32'(opc),    32'd0);
    chk("rst_fault",  32'(ffault), 32'd0);
    chk("rst_wpc",    w_pc,        32'hFFFF_FFFC);

    // zero-wait fetch
    reset_n = 1'b1;
    step();
    chk("zw_req",  32'(req), 32'd1);
    chk("zw_addr", addr,     32'h0000_0000);
    ack = 1'b1; rdata = 32'h0050_0093;
    step();
    ack = 1'b0; rdata = '0;
    chk("zw_valid", 32'(ivalid), 32'd1);
    chk("zw_instr", instr,       32'h0050_0093);
    chk("zw_op",    32'(opc),    32'h13);
    chk("zw_f3",    32'(f3),     32'd0);
    chk("zw_f7b5",  32'(f7b5),   32'd0);
    chk("zw_noreq", 32'(req),    32'd0);
    chk("zw_pcp4",  pcp4,        32'h0000_0004);

    // sequential retire, then one wait state
    step();
    chk("seq_req",   32'(req),    32'd1);
    chk("seq_addr",  addr,        32'h0000_0004);
    chk("seq_valid", 32'(ivalid), 32'd0);
    step();
    chk("wait_req",  32'(req),    32'd1);
    ack = 1'b1; rdata = 32'h4020_50B3; stall = 1'b1;
    step();
    ack = 1'b0;
    chk("sra_op",   32'(opc),  32'h33);
    chk("sra_f3",   32'(f3),   32'd5);
    chk("sra_f7b5", 32'(f7b5), 32'd1);

    // stall five cycles with stray acks that must be discarded
    for (int i = 0; i < 5; i++) begin
      ack = 1'b1; rdata = 32'hFFFF_FFFF;
      step();
      chk("stl_valid", 32'(ivalid), 32'd1);
      chk("stl_req",   32'(req),    32'd0);
      chk("stl_pc",    pc,          32'h0000_0004);
      chk("stl_instr", instr,       32'h4020_50B3);
    end
    ack = 1'b0; rdata = '0;
    stall = 1'b0; pcsrc = 1'b1; tgt = 32'h0000_0040;
    step();
    pcsrc = 1'b0; tgt = 32'hDEAD_BEEC;
    chk("br_req",   32'(req),    32'd1);
    chk("br_addr",  addr,        32'h0000_0040);
    chk("br_valid", 32'(ivalid), 32'd0);

    // watchdog: four FETCH cycles without ack
    repeat (3) step();
    chk("wd_pre_req",   32'(req),    32'd1);
    chk("wd_pre_fault", 32'(ffault), 32'd0);
    step();
    chk("wd_fault", 32'(ffault), 32'd1);
    chk("wd_req",   32'(req),    32'd0);
    chk("wd_valid", 32'(ivalid), 32'd0);
`ifdef MISALIGN_CHECK_EN
    chk("wd_cause", 32'(fcause), 32'd0);
`endif
    ack = 1'b1; rdata = 32'h1234_5678;
    step();
    ack = 1'b0;
    chk("wd_ack_fault", 32'(ffault), 32'd1);
    chk("wd_ack_valid", 32'(ivalid), 32'd0);
    chk("wd_ack_instr", instr,       32'h4020_50B3);

    // reset recovery, then reset mid-fetch
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    chk("rf_req",   32'(req),    32'd1);
    chk("rf_fault", 32'(ffault), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("rmf_req",   32'(req), 32'd0);
    chk("rmf_pc",    pc,       32'h0000_0000);
    chk("rmf_instr", instr,    32'd0);
    reset_n = 1'b1;
    step();
    chk("rmf_req2",  32'(req), 32'd1);
    chk("rmf_addr",  addr,     32'h0000_0000);

    // misaligned branch target
    ack = 1'b1; rdata = 32'h0000_0013;
    step();
    ack = 1'b0;
    chk("mis_valid", 32'(ivalid), 32'd1);
    chk("mis_pc",    pc,          32'h0000_0000);
    pcsrc = 1'b1; tgt = 32'h0000_0042;
    step();
    pcsrc = 1'b0; tgt = '0;
`ifdef MISALIGN_CHECK_EN
    chk("mis_fault", 32'(ffault), 32'd1);
    chk("mis_cause", 32'(fcause), 32'd1);
    chk("mis_pc2",   pc,          32'h0000_0000);
    chk("mis_req",   32'(req),    32'd0);
`else
    chk("mis_addr",  addr,        32'h0000_0040);
    chk("mis_req",   32'(req),    32'd1);
    chk("mis_fault", 32'(ffault), 32'd0);
`endif

    // PC+4 wrap on the second instance (watchdog disabled, long idle fetch)
    chk("w_fault", 32'(w_ffault), 32'd0);
    chk("w_req",   32'(w_req),    32'd1);
    chk("w_addr",  w_addr,        32'hFFFF_FFFC);
    w_ack = 1'b1; w_rdata = 32'h0000_0013;
    step();
    w_ack = 1'b0;
    chk("w_valid", 32'(w_ivalid), 32'd1);
    chk("w_pcp4",  w_pcp4,        32'h0000_0000);
    step();
    chk("w_wrap_addr", w_addr,     32'h0000_0000);
    chk("w_wrap_req",  32'(w_req), 32'd1);
`ifdef MISALIGN_CHECK_EN
    chk("w_cause", 32'(w_fcause), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
